secded_encoder: RTL

//   (72,64) SECDED encoder that produces the codewords secded_decoder consumes.

---
 rtl/secded_encoder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/secded_encoder.sv
// (72,64) SECDED encoder with a 2-stage elastic pipeline and a one-shot
// error injector used to exercise the decoder during bring-up.
module secded_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [63:0]      IN_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [71:0]      E_DATA,
    input  logic             INJ_ARM,
    input  logic [1:0]       INJ_MODE,
    input  logic [6:0]       INJ_POS_A,
    input  logic [6:0]       INJ_POS_B,
    output logic             INJ_BUSY,
    output logic [CNT_W-1:0] INJ_CNT
);

    localparam logic [7:0] H_COL [64] = '{
        8'h23, 8'h43, 8'h83, 8'h3D, 8'h45, 8'h85, 8'h89, 8'h49,
        8'h46, 8'h86, 8'h07, 8'h7A, 8'h8A, 8'h0B, 8'h13, 8'h92,
        8'h8C, 8'h0D, 8'h0E, 8'hF4, 8'h15, 8'h16, 8'h26, 8'h25,
        8'h19, 8'h1A, 8'h1C, 8'hE9, 8'h2A, 8'h2C, 8'h4C, 8'h4A,
        8'h32, 8'h34, 8'h38, 8'hD3, 8'h54, 8'h58, 8'h98, 8'h94,
        8'h64, 8'h68, 8'h70, 8'hA7, 8'hA8, 8'hB0, 8'h31, 8'h29,
        8'hC8, 8'hD0, 8'hE0, 8'h4F, 8'h51, 8'h61, 8'h62, 8'h52,
        8'h91, 8'hA1, 8'hC1, 8'h9E, 8'hA2, 8'hC2, 8'hC4, 8'hA4
    };

    logic        s1_v;
    logic        s1_inj;
    logic [63:0] s1_data;
    logic [71:0] s1_mask;
    logic        s2_v;
    logic        s2_inj;
    logic [71:0] s2_word;

    logic        inj_busy;
    logic        inj_dbl;
    logic [6:0]  pos_a;
    logic [6:0]  pos_b;

    logic [7:0]  chk;
    logic [71:0] inj_mask;
    logic        s1_load;
    logic        s2_load;
    logic        in_fire;
    logic        out_fire;
    logic        arm_ok;

    assign s2_load   = !s2_v || OUT_READY;
    assign s1_load   = !s1_v || s2_load;
    assign in_fire   = IN_VALID && s1_load;
    assign out_fire  = s2_v && OUT_READY;
    assign arm_ok    = INJ_ARM && !inj_busy &&
                       (INJ_MODE == 2'b01 || INJ_MODE == 2'b10);

    assign IN_READY  = s1_load;
    assign OUT_VALID = s2_v;
    assign E_DATA    = s2_word;
    assign INJ_BUSY  = inj_busy;

    always_comb begin
        chk = '0;
        for (int i = 0; i < 64; i++) begin
            chk = chk ^ (H_COL[i] & {8{s1_data[i]}});
        end
    end

    // Out-of-range positions match no bit, so they flip nothing.
    always_comb begin
        inj_mask = '0;
        for (int j = 0; j < 72; j++) begin
            inj_mask[j] = (pos_a == 7'(j)) ||
                          (inj_dbl && pos_b == 7'(j));
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            inj_busy <= 1'b0;
            inj_dbl  <= 1'b0;
            pos_a    <= '0;
            pos_b    <= '0;
        end else if (arm_ok) begin
            inj_busy <= 1'b1;
            inj_dbl  <= INJ_MODE[1];
            pos_a    <= INJ_POS_A;
            pos_b    <= INJ_POS_B;
        end else if (inj_busy && in_fire) begin
            inj_busy <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_v    <= 1'b0;
            s1_inj  <= 1'b0;
            s1_data <= '0;
            s1_mask <= '0;
        end else if (s1_load) begin
            s1_v <= IN_VALID;
            if (IN_VALID) begin
                s1_data <= IN_DATA;
                s1_inj  <= inj_busy;
                s1_mask <= inj_busy ? inj_mask : '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s2_v    <= 1'b0;
            s2_inj  <= 1'b0;
            s2_word <= '0;
        end else if (s2_load) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_word <= {chk, s1_data} ^ s1_mask;
                s2_inj  <= s1_inj;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            INJ_CNT <= '0;
        end else if (out_fire && s2_inj && INJ_CNT != '1) begin
            INJ_CNT <= INJ_CNT + CNT_W'(1);
        end
    end

endmodule
